// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divided clock. The divided clock is sampled as data in
// the I_ref_clk domain, and its period and high time are compared with the expected ratio.
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT_CYC = 511
) (
  input  logic       I_ref_clk,
  input  logic       I_rst_n,
  input  logic       I_en,
  input  logic [7:0] I_exp_ratio,
  input  logic       I_div_clk,
  input  logic       I_clr_err,
  output logic [7:0] o_period,
  output logic [7:0] o_high,
  output logic       o_meas_valid,
  output logic       o_match,
  output logic       o_locked,
  output logic       o_timeout,
  output logic       o_bypass,
  output logic [7:0] o_err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [9:0]             period_cnt_q, period_cnt_d;
  logic [9:0]             high_cnt_q, high_cnt_d;
  logic [9:0]             to_cnt_q, to_cnt_d;
  logic [3:0]             lock_q, lock_d;
  logic [7:0]             ratio_q;
  logic [7:0]             period_q, period_d;
  logic [7:0]             high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   match_q, match_d;
  logic                   timeout_q, timeout_d;
  logic                   bypass_q;
  logic [7:0]             err_q, err_d;

  logic       sync_s, rise, cfg_ok, cfg_chg, to_hit, meas_ok;
  logic [7:0] exp_high, meas_p, meas_h;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign rise     = sync_s & ~prev_q;
  assign cfg_ok   = I_en & (I_exp_ratio >= 8'd2);
  assign cfg_chg  = (I_exp_ratio != ratio_q);
  assign to_hit   = (to_cnt_q == 10'(TIMEOUT_CYC - 1));
  // N/2 for even N and (N-1)/2 for odd N are both a right shift
  assign exp_high = {1'b0, I_exp_ratio[7:1]};
  assign meas_p   = (period_cnt_q > 10'd255) ? 8'hFF : period_cnt_q[7:0];
  assign meas_h   = (high_cnt_q > 10'd255) ? 8'hFF : high_cnt_q[7:0];
  assign meas_ok  = (meas_p == I_exp_ratio) && (meas_h == exp_high);

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I_div_clk};
      prev_q <= sync_s;
    end
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= S_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      to_cnt_q     <= '0;
      lock_q       <= '0;
      ratio_q      <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      match_q      <= 1'b0;
      timeout_q    <= 1'b0;
      bypass_q     <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      to_cnt_q     <= to_cnt_d;
      lock_q       <= lock_d;
      ratio_q      <= I_exp_ratio;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      match_q      <= match_d;
      timeout_q    <= timeout_d;
      bypass_q     <= I_en & (I_exp_ratio < 8'd2);
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    to_cnt_d     = to_cnt_q;
    lock_d       = lock_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = 1'b0;
    match_d      = match_q;
    timeout_d    = timeout_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        to_cnt_d     = '0;
        lock_d       = '0;
        if (cfg_ok) state_d = S_ARM;
      end
      S_ARM, S_MEAS: begin
        if (!cfg_ok || cfg_chg) begin
          state_d      = cfg_ok ? S_ARM : S_IDLE;
          period_cnt_d = '0;
          high_cnt_d   = '0;
          to_cnt_d     = '0;
          lock_d       = '0;
        end else if (rise) begin
          // Close the running period and start the next one in the same cycle
          state_d      = S_MEAS;
          period_cnt_d = 10'd1;
          high_cnt_d   = 10'd1;
          to_cnt_d     = '0;
          if (state_q == S_MEAS) begin
            period_d = meas_p;
            high_d   = meas_h;
            valid_d  = 1'b1;
            match_d  = meas_ok;
            if (meas_ok) begin
              lock_d = (lock_q == 4'(LOCK_COUNT)) ? lock_q : lock_q + 4'd1;
            end else begin
              lock_d = '0;
              err_d  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end
          end
        end else if (to_hit) begin
          state_d      = S_ARM;
          timeout_d    = 1'b1;
          lock_d       = '0;
          match_d      = 1'b0;
          period_cnt_d = '0;
          high_cnt_d   = '0;
          to_cnt_d     = '0;
        end else begin
          to_cnt_d = to_cnt_q + 10'd1;
          if (state_q == S_MEAS) begin
            period_cnt_d = period_cnt_q + 10'd1;
            high_cnt_d   = high_cnt_q + 10'(sync_s);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (I_clr_err) begin
      err_d     = '0;
      timeout_d = 1'b0;
    end
  end

  assign o_period     = period_q;
  assign o_high       = high_q;
  assign o_meas_valid = valid_q;
  assign o_match      = match_q;
  assign o_locked     = (lock_q == 4'(LOCK_COUNT));
  assign o_timeout    = timeout_q;
  assign o_bypass     = bypass_q;
  assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a divided-clock generator runs on the falling
// edge of the reference clock; outputs are sampled on falling edges.
module tb_clk_div_monitor;

  logic       I_ref_clk = 1'b0;
  logic       I_rst_n;
  logic       I_en;
  logic [7:0] I_exp_ratio;
  logic       I_div_clk = 1'b0;
  logic       I_clr_err;
  logic [7:0] o_period, o_high, o_err_cnt;
  logic       o_meas_valid, o_match, o_locked, o_timeout, o_bypass;

  int checks = 0;
  int fails  = 0;

  int gen_hi = 1, gen_lo = 1, ph = 0;
  bit gen_on = 1'b0;

  clk_div_monitor #(.SYNC_STAGES(2), .LOCK_COUNT(4), .TIMEOUT_CYC(511)) dut (
    .I_ref_clk(I_ref_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_exp_ratio(I_exp_ratio),
    .I_div_clk(I_div_clk), .I_clr_err(I_clr_err), .o_period(o_period), .o_high(o_high),
    .o_meas_valid(o_meas_valid), .o_match(o_match), .o_locked(o_locked),
    .o_timeout(o_timeout), .o_bypass(o_bypass), .o_err_cnt(o_err_cnt)
  );

  always #5 I_ref_clk = ~I_ref_clk;

  always @(negedge I_ref_clk) begin
    if (gen_on) begin
      I_div_clk = (ph < gen_hi);
      ph = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
    end else begin
      I_div_clk = 1'b0;
    end
  end

  task automatic start_gen(input int hi, input int lo);
    gen_hi = hi; gen_lo = lo; ph = 0; gen_on = 1'b1;
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    do begin
      @(negedge I_ref_clk);
      waited++;
    end while (!o_meas_valid && waited < 2000);
    if (!o_meas_valid) begin
      checks++; fails++;
      $display("FAIL wait_valid: no o_meas_valid within %0d cycles", waited);
    end
  endtask

  task automatic test_reset;
    I_rst_n = 1'b0; I_en = 1'b0; I_exp_ratio = 8'd0; I_clr_err = 1'b0; gen_on = 1'b0;
    repeat (3) @(negedge I_ref_clk);
    checks++;
    if ({o_period, o_high, o_meas_valid, o_match, o_locked, o_timeout, o_bypass, o_err_cnt} !== '0) begin
      fails++; $display("FAIL reset_outputs: got period=%0d high=%0d err=%0d flags=%b, want all 0",
        o_period, o_high, o_err_cnt, {o_meas_valid, o_match, o_locked, o_timeout, o_bypass});
    end
    #1 I_rst_n = 1'b1;
    @(negedge I_ref_clk);
    checks++;
    if ({o_period, o_high, o_meas_valid, o_match, o_locked, o_timeout, o_bypass, o_err_cnt} !== '0) begin
      fails++; $display("FAIL post_reset_idle: outputs not all 0 after release");
    end
  endtask

  task automatic test_ratio4;
    int w;
    #1 I_exp_ratio = 8'd4; start_gen(2, 2); I_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wait_valid(w);
      checks++;
      if (o_period !== 8'd4 || o_high !== 8'd2 || o_match !== 1'b1) begin
        fails++; $display("FAIL r4_meas[%0d]: got p=%0d h=%0d m=%b, want p=4 h=2 m=1", i, o_period, o_high, o_match);
      end
      checks++;
      if (o_locked !== (i >= 4)) begin
        fails++; $display("FAIL r4_lock[%0d]: got %b want %b", i, o_locked, (i >= 4));
      end
      if (i > 1) begin
        checks++;
        if (w != 4) begin fails++; $display("FAIL r4_interval[%0d]: got %0d want 4", i, w); end
      end
    end
    #1 I_en = 1'b0; gen_on = 1'b0;
    repeat (3) @(negedge I_ref_clk);
    checks++;
    if (o_locked !== 1'b0 || o_period !== 8'd4 || o_match !== 1'b1) begin
      fails++; $display("FAIL r4_disable_hold: got lock=%b p=%0d m=%b want lock=0 p=4 m=1", o_locked, o_period, o_match);
    end
  endtask

  task automatic test_ratio7_2;
    int w;
    #1 I_exp_ratio = 8'd7; start_gen(3, 4); I_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_valid(w);
      checks++;
      if (o_period !== 8'd7 || o_high !== 8'd3 || o_match !== 1'b1) begin
        fails++; $display("FAIL r7_meas[%0d]: got p=%0d h=%0d m=%b, want p=7 h=3 m=1", i, o_period, o_high, o_match);
      end
      if (i > 1) begin
        checks++;
        if (w != 7) begin fails++; $display("FAIL r7_interval[%0d]: got %0d want 7", i, w); end
      end
    end
    #1 I_en = 1'b0; gen_on = 1'b0;
    repeat (4) @(negedge I_ref_clk);
    #1 I_exp_ratio = 8'd2; start_gen(1, 1); I_en = 1'b1;
    wait_valid(w);
    for (int i = 1; i <= 8; i++) begin
      wait_valid(w);
      checks++;
      if (w != 2 || o_period !== 8'd2 || o_high !== 8'd1 || o_match !== 1'b1) begin
        fails++; $display("FAIL r2_meas[%0d]: got gap=%0d p=%0d h=%0d m=%b, want gap=2 p=2 h=1 m=1",
          i, w, o_period, o_high, o_match);
      end
    end
  endtask

  task automatic test_mismatch;
    int w;
    #1 I_en = 1'b0; gen_on = 1'b0; I_clr_err = 1'b1;
    @(negedge I_ref_clk);
    #1 I_clr_err = 1'b0; I_exp_ratio = 8'd6; start_gen(2, 3); I_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(w);
      checks++;
      if (o_period !== 8'd5 || o_high !== 8'd2 || o_match !== 1'b0 || o_locked !== 1'b0 || o_err_cnt !== 8'(i)) begin
        fails++; $display("FAIL mis_meas[%0d]: got p=%0d h=%0d m=%b l=%b err=%0d, want p=5 h=2 m=0 l=0 err=%0d",
          i, o_period, o_high, o_match, o_locked, o_err_cnt, i);
      end
    end
    #1 I_clr_err = 1'b1;
    @(negedge I_ref_clk);
    checks++;
    if (o_err_cnt !== 8'd0) begin fails++; $display("FAIL clr_err: got %0d want 0", o_err_cnt); end
    #1 I_clr_err = 1'b0;
    for (int i = 0; i < 300; i++) wait_valid(w);
    checks++;
    if (o_err_cnt !== 8'd255) begin fails++; $display("FAIL err_saturate: got %0d want 255", o_err_cnt); end
  endtask

  task automatic test_timeout;
    int w, nv, vcnt;
    #1 I_en = 1'b0; gen_on = 1'b0; I_clr_err = 1'b1;
    @(negedge I_ref_clk);
    #1 I_clr_err = 1'b0; I_exp_ratio = 8'd8; start_gen(4, 4); I_en = 1'b1;
    nv = 0;
    do begin wait_valid(w); nv++; end while (!o_locked && nv < 8);
    checks++;
    if (o_locked !== 1'b1 || nv != 4) begin
      fails++; $display("FAIL to_prelock: got lock=%b at valid %0d, want lock=1 at 4", o_locked, nv);
    end
    #1 gen_on = 1'b0;
    vcnt = 0;
    for (int k = 1; k <= 511; k++) begin
      @(negedge I_ref_clk);
      if (o_meas_valid) vcnt++;
      if (k == 510) begin
        checks++;
        if (o_timeout !== 1'b0) begin fails++; $display("FAIL to_early: got timeout=1 at 510 cycles want 0"); end
      end
      if (k == 511) begin
        checks++;
        if (o_timeout !== 1'b1 || o_locked !== 1'b0 || o_match !== 1'b0) begin
          fails++; $display("FAIL to_fire: got to=%b lock=%b m=%b, want to=1 lock=0 m=0", o_timeout, o_locked, o_match);
        end
      end
    end
    checks++;
    if (vcnt != 0) begin fails++; $display("FAIL to_novalid: got %0d valids want 0", vcnt); end
    #1 start_gen(4, 4);
    nv = 0;
    do begin wait_valid(w); nv++; end while (!o_locked && nv < 8);
    checks++;
    if (o_locked !== 1'b1 || nv != 4 || o_timeout !== 1'b1) begin
      fails++; $display("FAIL to_relock: got lock=%b at valid %0d to=%b, want lock=1 at 4 to=1", o_locked, nv, o_timeout);
    end
    #1 I_clr_err = 1'b1;
    @(negedge I_ref_clk);
    checks++;
    if (o_timeout !== 1'b0) begin fails++; $display("FAIL to_clear: got %b want 0", o_timeout); end
    #1 I_clr_err = 1'b0;
  endtask

  task automatic test_bypass;
    int vcnt;
    #1 I_en = 1'b0; gen_on = 1'b0;
    @(negedge I_ref_clk);
    #1 I_exp_ratio = 8'd1; I_en = 1'b1; start_gen(1, 1);
    @(negedge I_ref_clk);
    checks++;
    if (o_bypass !== 1'b1) begin fails++; $display("FAIL bypass_on: got %b want 1", o_bypass); end
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge I_ref_clk);
      if (o_meas_valid) vcnt++;
    end
    checks++;
    if (vcnt != 0 || o_bypass !== 1'b1) begin
      fails++; $display("FAIL bypass_novalid: got valids=%0d bypass=%b want 0 and 1", vcnt, o_bypass);
    end
    #1 I_en = 1'b0;
    @(negedge I_ref_clk);
    checks++;
    if (o_bypass !== 1'b0) begin fails++; $display("FAIL bypass_off: got %b want 0", o_bypass); end
  endtask

  task automatic test_cfg_change;
    int w, nv;
    #1 I_exp_ratio = 8'd4; start_gen(2, 2); I_en = 1'b1;
    nv = 0;
    do begin wait_valid(w); nv++; end while (!o_locked && nv < 8);
    checks++;
    if (o_locked !== 1'b1) begin fails++; $display("FAIL cfg_prelock: got %b want 1", o_locked); end
    #1 I_exp_ratio = 8'd8; start_gen(4, 4);
    @(negedge I_ref_clk);
    checks++;
    if (o_locked !== 1'b0 || o_meas_valid !== 1'b0 || o_period !== 8'd4) begin
      fails++; $display("FAIL cfg_change: got lock=%b v=%b p=%0d want lock=0 v=0 p=4", o_locked, o_meas_valid, o_period);
    end
    wait_valid(w);
    checks++;
    if (w != 11 || o_period !== 8'd8 || o_high !== 8'd4 || o_match !== 1'b1 || o_locked !== 1'b0) begin
      fails++; $display("FAIL cfg_first8: got gap=%0d p=%0d h=%0d m=%b l=%b want gap=11 p=8 h=4 m=1 l=0",
        w, o_period, o_high, o_match, o_locked);
    end
    wait_valid(w);
    checks++;
    if (w != 8 || o_period !== 8'd8 || o_match !== 1'b1) begin
      fails++; $display("FAIL cfg_second8: got gap=%0d p=%0d m=%b want gap=8 p=8 m=1", w, o_period, o_match);
    end
  endtask

  task automatic test_reset_mid;
    int w;
    @(negedge I_ref_clk);
    #3 I_rst_n = 1'b0; gen_on = 1'b0;
    #1;
    checks++;
    if ({o_period, o_high, o_meas_valid, o_match, o_locked, o_timeout, o_bypass, o_err_cnt} !== '0) begin
      fails++; $display("FAIL async_reset: got p=%0d h=%0d err=%0d flags=%b want all 0",
        o_period, o_high, o_err_cnt, {o_meas_valid, o_match, o_locked, o_timeout, o_bypass});
    end
    @(negedge I_ref_clk);
    #1 I_rst_n = 1'b1; start_gen(4, 4);
    wait_valid(w);
    checks++;
    if (w != 12 || o_period !== 8'd8 || o_high !== 8'd4 || o_match !== 1'b1) begin
      fails++; $display("FAIL reset_first_valid: got gap=%0d p=%0d h=%0d m=%b want gap=12 p=8 h=4 m=1",
        w, o_period, o_high, o_match);
    end
  endtask

  initial begin
    test_reset();
    test_ratio4();
    test_ratio7_2();
    test_mismatch();
    test_timeout();
    test_bypass();
    test_cfg_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
